// File: rtl/tdm_demux4.sv
// tdm_demux4: 1-to-4 word demultiplexer with one-entry valid/ready holding registers per channel.
// Define TDM_DEMUX4_AUTOSEL_EN to steer words with the internal round-robin sequencer instead of sel.
module tdm_demux4 #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [1:0]         sel,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic [3:0]         ch_valid,
   input  logic [3:0]         ch_ready,
   output logic [4*WIDTH-1:0] ch_data,
   output logic [1:0]         cur_ch,
   output logic               frame_done
);

   logic [1:0]            tgt;
   logic                  accept;
   logic [3:0]            load;
   logic [3:0]            consume;
   logic [3:0]            vld_p1;
   logic [3:0][WIDTH-1:0] data_p1;
   logic                  fd_p1;

`ifdef TDM_DEMUX4_AUTOSEL_EN
   typedef enum logic [1:0] {
      CH0 = 2'd0,
      CH1 = 2'd1,
      CH2 = 2'd2,
      CH3 = 2'd3
   } state_t;

   state_t state, state_nxt;
   logic [1:0] unused_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CH0;
      end else begin
         state <= state_nxt;
      end
   end

   // Sequencer only moves on an accepted word; flush parks it on channel 0.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = CH0;
      end else if (accept) begin
         case (state)
            CH0:     state_nxt = CH1;
            CH1:     state_nxt = CH2;
            CH2:     state_nxt = CH3;
            CH3:     state_nxt = CH0;
            default: state_nxt = CH0;
         endcase
      end
   end

   assign unused_sel = sel;
   assign tgt        = state;
`else
   assign tgt = sel;
`endif

   assign cur_ch = tgt;

   // A full target that is draining this cycle still accepts (pass-through).
   assign in_ready = !flush && (!vld_p1[tgt] || ch_ready[tgt]);
   assign accept   = in_valid && in_ready;

   always_comb begin
      load = 4'b0000;
      if (accept) begin
         load[tgt] = 1'b1;
      end
      consume = vld_p1 & ch_ready;
   end

   // ---- stage p1: channel holding registers and frame pulse ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= '0;
         data_p1 <= '0;
         fd_p1   <= 1'b0;
      end else if (flush) begin
         vld_p1 <= '0;
         fd_p1  <= 1'b0;
      end else begin
         fd_p1 <= accept && (&tgt);
         for (int i = 0; i < 4; i++) begin
            if (load[i]) begin
               vld_p1[i]  <= 1'b1;
               data_p1[i] <= in_data;
            end else if (consume[i]) begin
               vld_p1[i] <= 1'b0;
            end
         end
      end
   end

   assign ch_valid   = vld_p1;
   assign ch_data    = data_p1;
   assign frame_done = fd_p1;

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Sequenced 1-to-4 demultiplexer: the receive-side counterpart of the team's 4:1 gate-level multiplexer. It takes one input word stream and steers each accepted word into one of four registered output channels. The channel is picked either by an external 2-bit select or by an internal round-robin sequencer. Each channel has a one-entry holding register with valid/ready flow control, and a full channel back-pressures the input.

## Interface
Parameters:
- WIDTH, 8, data width of the input word and of each channel

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of all channel valids and the sequencer
- sel  input  2  external channel select (sel[1]=S1, sel[0]=S0); ignored when the auto-select feature is compiled in
- in_valid  input  1  input word present
- in_ready  output  1  input word is accepted this cycle when high together with in_valid
- in_data  input  WIDTH  input word
- ch_valid  output  4  bit i high means channel i holds a word
- ch_ready  input  4  bit i high means the consumer takes channel i this cycle
- ch_data  output  4*WIDTH  channel i data is at [i*WIDTH +: WIDTH]
- cur_ch  output  2  target channel for the current cycle
- frame_done  output  1  registered one-cycle pulse after a word is accepted into channel 3

## Operation
- Target channel t = cur_ch.
  - Auto-select mode: cur_ch is the sequencer state.
  - Manual mode: cur_ch = sel.
- Sequencer FSM, states CH0→CH1→CH2→CH3→CH0. It advances only on an accepted word (in_valid && in_ready). CH3 wraps to CH0.
- in_ready = !ch_valid[t] || ch_ready[t]. This is combinational and is a pass-through when the target channel is draining in the same cycle.
- On accept:
  - ch_data[t] ← in_data.
  - ch_valid[t] ← 1.
  - The other channels are unaffected.
- On consume of channel i (ch_valid[i] && ch_ready[i]) without a load to i: ch_valid[i] ← 0. ch_data[i] holds its last value.
- Simultaneous consume and load on the same channel: the new word is loaded and ch_valid stays 1. No bubble.
- Consumes on non-target channels proceed in parallel with the accept.
- frame_done ← 1 for one cycle after any accept with t=3, in both modes.
- flush = 1, evaluated at the clock edge:
  - ch_valid ← 0, sequencer ← CH0, frame_done ← 0.
  - The input word in that cycle is not accepted: in_ready is forced 0 while flush is high.
  - ch_data is unchanged.
- Reset values (asynchronous, immediate on rst rising):
  - ch_valid=4'b0000, ch_data=0, sequencer=CH0 (cur_ch=0 in auto-select mode), frame_done=0.
  - in_ready=1 after reset when flush=0, because the target channel is empty.
- Reset mid-operation drops all held words. No partial state survives.
- ch_ready on a channel with ch_valid=0 has no effect.
- in_data is don't-care when in_valid=0.

## Timing
- Latency is 1 cycle: a word accepted at edge n is visible on ch_data/ch_valid after edge n.
- Throughput is 1 word/cycle when consumers keep ch_ready high.
- frame_done is asserted in the cycle after the channel-3 accept.
- There is a combinational path ch_ready/sel → in_ready. There is no path in_valid → in_ready.
- flush has priority over accept and consume.
- rst has priority over everything.

## Configuration
- TDM_DEMUX4_AUTOSEL_EN
  - Defined: the target channel comes from the internal round-robin sequencer and sel is ignored. cur_ch shows the sequencer state.
  - Not defined: the target channel is sel every cycle. The sequencer is not built, and cur_ch = sel.
  - Everything else is identical in both modes: flow control, frame_done, flush and reset.

## Test plan
- Reset, then auto mode, ch_ready=4'hF, in_valid held, in_data=8'h10,11,12,13,14 → ch_data[0..3]=10,11,12,13 and channel 0 then gets 14; cur_ch sequence 0,1,2,3,0; frame_done pulses once, the cycle after the 8'h13 accept.
- Auto mode, ch_ready=0, five words offered → four accepted, ch_valid=4'hF; the fifth is held with in_ready=0 until ch_ready[0]=1. In that cycle the fifth word is accepted and ch_valid[0] stays 1 with the new data.
- Manual mode, sel=2'b10, in_data=8'hA5, then sel=2'b01, in_data=8'h3C → ch_valid=4'b0110, channel 2=A5, channel 1=3C; frame_done stays 0.
- Assert flush with ch_valid=4'b1011 and in_valid=1 → the next cycle ch_valid=0, cur_ch=0 (auto mode); the flush-cycle word is not accepted.
- Assert rst asynchronously (mid-cycle) with ch_valid=4'hF and the sequencer at CH2 → all outputs go to their reset values immediately, without a clock edge; the first word after rst release goes to channel 0.
- Simultaneous events: target channel 1 full with ch_ready[1]=1, and ch_ready[3]=1 with channel 3 full → both drain, channel 1 reloads with the new word, ch_valid[3]→0.
